// File: rtl/cell_particle_fetcher_pkg.sv
// Shared constants for the cell particle fetcher.
// Holds the FSM encoding, memory read latency and default buffer depth.
package cell_particle_fetcher_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_CNT   = 3'd1;
    localparam logic [2:0] S_WAIT_CNT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_FINISH   = 3'd4;

    localparam int MEM_RD_LATENCY     = 2;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/cell_particle_fetcher_fetch_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on rdata.
// Ports: clk, rst, push/wdata, pop, rdata, occupancy, empty.
module fetch_fifo #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [OCC_W-1:0] occupancy,
    output logic             empty
);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full, do_push, do_pop;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_W'(DEPTH));
    assign occupancy = occ_q;
    assign rdata     = buf_q[rd_q];
    assign do_pop    = pop && !empty;
    // a push into a full FIFO is fine when the head leaves this cycle
    assign do_push   = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (do_push) begin
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            if (do_push) begin
                buf_q[wr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/cell_particle_fetcher.sv
// Drains one cell's position memory: reads the count at address 0, then
// streams words 1..count out over valid/ready, tagged with id and last.
// Ports: start/busy/done/cnt_err/particle_count control, mem_* memory
// side (2-cycle read latency), out_* streaming side.
module cell_particle_fetcher
    import cell_particle_fetcher_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_particle_id,
    output logic                  out_last
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int L     = MEM_RD_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    logic [2:0]            state_q, state_d;
    logic                  wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [L-1:0]          infl_q, infl_d;
    logic [ADDR_WIDTH-1:0] id_q [L];
    logic [ADDR_WIDTH-1:0] id_d [L];

    logic [ADDR_WIDTH-1:0] cnt_word;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W:0]        pending;
    logic [EW-1:0]         wdata, rdata;
    logic                  empty, issue, push, pop, drained;

    assign cnt_word = mem_q[ADDR_WIDTH-1:0];
    assign push     = infl_q[L-1];
    assign pop      = out_valid && out_ready;
    assign wdata    = {mem_q, id_q[L-1], id_q[L-1] == cnt_q};

    // reads are only issued when their data is guaranteed a FIFO slot
    always_comb begin
        pending = {1'b0, occ};
        for (int i = 0; i < L; i++) begin
            pending = pending + (OCC_W + 1)'(infl_q[i]);
        end
    end

    assign issue = (state_q == S_STREAM)
                && (pending < (OCC_W + 1)'(FIFO_DEPTH))
                && (ptr_q <= cnt_q);

    // exit on the cycle the final word leaves, so done follows directly
    assign drained = (ptr_q > cnt_q) && (infl_q == '0)
                  && (empty || (occ == OCC_W'(1) && pop));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        infl_d  = {infl_q[L-2:0], issue};
        id_d[0] = ptr_q;
        for (int i = 1; i < L; i++) begin
            id_d[i] = id_q[i-1];
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_CNT;
                    err_d   = 1'b0;
                end
            end
            S_RD_CNT: begin
                state_d = S_WAIT_CNT;
                wcnt_d  = 1'b0;
            end
            S_WAIT_CNT: begin
                wcnt_d = 1'b1;
                if (wcnt_q) begin
                    // a zero count spends one empty STREAM cycle
                    state_d = S_STREAM;
                    ptr_d   = ADDR_WIDTH'(1);
                    if (cnt_word > MAX_CNT) begin
                        cnt_d = MAX_CNT;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_word;
                    end
                end
            end
            S_STREAM: begin
                if (issue) begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
                if (drained) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            infl_q  <= '0;
            id_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            infl_q  <= infl_d;
            id_q    <= id_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (wdata),
        .pop       (pop),
        .rdata     (rdata),
        .occupancy (occ),
        .empty     (empty)
    );

    assign busy            = (state_q == S_RD_CNT) || (state_q == S_WAIT_CNT)
                          || (state_q == S_STREAM);
    assign done            = (state_q == S_FINISH);
    assign cnt_err         = err_q;
    assign particle_count  = cnt_q;
    assign mem_rden        = (state_q == S_RD_CNT) || issue;
    assign mem_address     = issue ? ptr_q : '0;
    assign mem_wren        = 1'b0;
    assign out_valid       = !empty;
    assign out_data        = rdata[EW-1 -: DATA_WIDTH];
    assign out_particle_id = rdata[ADDR_WIDTH:1];
    assign out_last        = rdata[0];

endmodule

// File: tb/tb_cell_particle_fetcher.sv
// Bench for cell_particle_fetcher: memory model with 2-cycle latency,
// scoreboard of expected words, table of fetches plus corner sequences.
module tb_cell_particle_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, cnt_err, mem_rden, mem_wren;
    logic [7:0]  particle_count, mem_address, out_particle_id;
    logic [95:0] mem_q = '0;
    logic        out_valid, out_last;
    logic        out_ready = 1'b0;
    logic [95:0] out_data;

    cell_particle_fetcher dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .cnt_err         (cnt_err),
        .particle_count  (particle_count),
        .mem_address     (mem_address),
        .mem_rden        (mem_rden),
        .mem_wren        (mem_wren),
        .mem_q           (mem_q),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_particle_id (out_particle_id),
        .out_last        (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [95:0] mem [0:219];
    logic [95:0] s1 = '0;
    always @(posedge clk) begin
        if (mem_rden && mem_address < 8'd220) s1 <= mem[mem_address];
        else s1 <= {3{32'hBAD0_BAD0}};
        mem_q <= s1;
    end

    typedef struct {
        logic [95:0] data;
        logic [7:0]  id;
        logic        last;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [95:0] cw;
        int          mode;
        int          n;
        logic        err;
        int          done_off;
        int          fv_off;
    } vec_t;
    vec_t vt[8];

    int n_cmp = 0;
    int n_mis = 0;
    int iss = 0;
    int pops = 0;
    int first_v = -1;
    int rdy_mode = 0;
    logic         hold_v = 1'b0;
    logic [104:0] hold_w = '0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic monitor_cycle();
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
            return;
        end
        chk("wren_zero", 128'(mem_wren), 128'(0));
        if (!mem_rden) chk("addr_idle", 128'(mem_address), 128'(0));
        if (mem_rden && mem_address != '0) begin
            chk("no_issue_when_full", 128'((iss - pops) < 4), 128'(1));
            iss++;
        end
        if (hold_v) begin
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_word", 128'({out_data, out_particle_id, out_last}),
                128'(hold_w));
        end
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_word: got id %0d required none",
                         out_particle_id);
            end else begin
                e = sb.pop_front();
                chk("out_data", 128'(out_data), 128'(e.data));
                chk("out_id", 128'(out_particle_id), 128'(e.id));
                chk("out_last", 128'(out_last), 128'(e.last));
            end
            pops++;
        end
        hold_v = out_valid && !out_ready;
        hold_w = {out_data, out_particle_id, out_last};
    endtask

    task automatic drive_ready();
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [95:0] cw, input int seed,
                            output int t0, output int n);
        logic [31:0] px, py, pz;
        mem[0] = cw;
        n = (int'(cw[7:0]) > 219) ? 219 : int'(cw[7:0]);
        for (int i = 1; i < 220; i++) begin
            px = 32'(seed * 65536 + i);
            py = 32'hA000_0000 + 32'(i);
            pz = 32'(i * 7 + seed);
            mem[i] = {pz, py, px};
        end
        sb.delete();
        for (int i = 1; i <= n; i++) begin
            sb.push_back('{data: mem[i], id: 8'(i), last: (i == n)});
        end
        iss = 0;
        pops = 0;
        first_v = -1;
        tick();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        chk("busy_T1", 128'(busy), 128'(1));
        chk("err_clear_T1", 128'(cnt_err), 128'(0));
    endtask

    task automatic wait_done(input int t0, input int exp_off, input int n,
                             input logic err);
        int dc;
        dc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL done_timeout: got no done required done");
        end else begin
            if (exp_off >= 0) chk("done_cycle", 128'(dc - t0), 128'(exp_off));
            chk("busy_at_done", 128'(busy), 128'(0));
        end
        chk("particle_count", 128'(particle_count), 128'(n));
        chk("cnt_err", 128'(cnt_err), 128'(err));
        chk("reads_issued", 128'(iss), 128'(n));
        chk("delivered", 128'(pops), 128'(n));
        chk("sb_empty", 128'(sb.size()), 128'(0));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy, done, cnt_err, particle_count, mem_address,
                     mem_rden, mem_wren, out_valid, out_data,
                     out_particle_id, out_last});
    endfunction

    initial begin
        int t0, n;
        vt[0] = '{96'd5,   0, 5,   1'b0, 12,  7};
        vt[1] = '{96'd0,   0, 0,   1'b0, 5,   -1};
        vt[2] = '{96'd200, 1, 200, 1'b0, -1,  7};
        vt[3] = '{96'd250, 0, 219, 1'b1, 226, 7};
        vt[4] = '{96'd3,   0, 3,   1'b0, 10,  7};
        vt[5] = '{96'd219, 0, 219, 1'b0, 226, 7};
        vt[6] = '{96'hABCD_0000_0000_0000_0000_0001, 0, 1, 1'b0, 8, 7};
        vt[7] = '{96'd220, 0, 219, 1'b1, 226, 7};

        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
            forever begin
                tick();
                drive_ready();
            end
        join_none

        tick();
        tick();
        chk("reset_outputs", all_outs(), 128'(0));
        rst = 1'b0;
        tick();
        chk("after_reset_outputs", all_outs(), 128'(0));

        for (int k = 0; k < 8; k++) begin
            rdy_mode = vt[k].mode;
            do_start(vt[k].cw, k + 3, t0, n);
            tick();
            tick();
            tick();
            chk("err_T4", 128'(cnt_err), 128'(vt[k].err));
            chk("count_T4", 128'(particle_count), 128'(vt[k].n));
            wait_done(t0, vt[k].done_off, vt[k].n, vt[k].err);
            if (vt[k].fv_off >= 0)
                chk("first_valid", 128'(first_v - t0), 128'(vt[k].fv_off));
            else
                chk("never_valid", 128'(first_v < 0), 128'(1));
        end

        // 20 stalled cycles from the first valid word
        rdy_mode = 2;
        do_start(96'd10, 21, t0, n);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_first_valid", 128'(cyc - t0), 128'(7));
        repeat (19) @(negedge clk);
        rdy_mode = 0;
        tick();
        chk("bp_reads_stalled", 128'(iss), 128'(4));
        wait_done(t0, 37, 10, 1'b0);

        // start ignored mid-stream, then reset with 3 words buffered
        rdy_mode = 2;
        do_start(96'd50, 33, t0, n);
        repeat (7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_busy", 128'(busy), 128'(1));
        chk("ign_start_rden", 128'(mem_rden), 128'(0));
        chk("ign_start_count", 128'(particle_count), 128'(50));
        chk("ign_start_reads", 128'(iss), 128'(4));
        chk("buffered_head_id", 128'(out_particle_id), 128'(1));
        rst = 1'b1;
        sb.delete();
        iss = 0;
        pops = 0;
        #1;
        chk("midstream_reset_outputs", all_outs(), 128'(0));
        tick();
        rst = 1'b0;
        chk("post_reset_outputs", all_outs(), 128'(0));
        rdy_mode = 0;
        repeat (12) tick();
        chk("no_stale_words", 128'(pops), 128'(0));
        chk("idle_after_reset", 128'(busy), 128'(0));

        rdy_mode = 1;
        do_start(96'd4, 44, t0, n);
        wait_done(t0, -1, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
